adder_chunk_scheduler: RTL and testbench
========================================

// Module: adder_chunk_scheduler
// PURPOSE
//   Shares one external 3-bit carry-lookahead adder between NUM_REQ requesters.
//   Each request is a WIDTH-bit add (WIDTH = 3*CHUNKS). The block arbitrates
//   round-robin, then steps the shared adder one 3-bit chunk per cycle, LSB first,
//   rippling carry through a register. It returns sum, carry-out and requester id
//   on a valid/ready response port.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..8)
//   CHUNKS    3   3-bit chunks per operand; WIDTH = 3*CHUNKS (default 9)
// PORTS
//   clk        in   1              clock; all state updates on negedge clk
//   reset      in   1              asynchronous, active-high reset
//   req_valid  in   NUM_REQ        per-requester request valid
//   req_ready  out  NUM_REQ        per-requester accept (one-hot or zero)
//   req_x      in   NUM_REQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH]
//   req_y      in   NUM_REQ*WIDTH  operand y, same packing
//   req_cin    in   NUM_REQ        carry-in per requester
//   add_x      out  3              shared adder operand x (current chunk)
//   add_y      out  3              shared adder operand y (current chunk)
//   add_cin    out  1              shared adder carry-in
//   add_out    in   3              shared adder sum (combinational return)
//   add_cout   in   1              shared adder carry-out
//   rsp_valid  out  1              response valid
//   rsp_ready  in   1              response accept
//   rsp_id     out  clog2(NUM_REQ) index of the served requester
//   rsp_sum    out  WIDTH          sum
//   rsp_cout   out  1              final carry-out
// BEHAVIOUR
//   Reset: state=IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, cnt=0.
//     Also rr_ptr=NUM_REQ-1, so requester 0 wins first. Reset mid-RUN/DONE aborts
//     the transaction; no response is issued.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: grant = first asserted req_valid scanning from rr_ptr+1 with wrap.
//     req_ready[grant]=1 combinationally; all other bits 0. If no valid, req_ready=0.
//     On the edge: latch x, y, cin and id of grant; carry<=cin; cnt<=0; go RUN.
//   RUN: add_x=x_reg[3*cnt+:3], add_y=y_reg[3*cnt+:3], add_cin=carry.
//     On the edge: sum_reg[3*cnt+:3]<=add_out; carry<=add_cout; cnt<=cnt+1.
//     When cnt==CHUNKS-1, go DONE.
//   Outside RUN, add_x/add_y/add_cin are driven 0.
//   DONE: rsp_valid=1; rsp_sum/rsp_cout/rsp_id are stable while rsp_valid & !rsp_ready.
//     On rsp_ready: rr_ptr<=id, rsp_valid<=0, go IDLE.
//   Latency: rsp_valid is high exactly CHUNKS+1 cycles after the accept cycle.
//     Minimum spacing between accepts is CHUNKS+2 cycles.
//   req_ready is never high outside IDLE. Requests not yet accepted may drop
//     valid freely; operand changes after accept have no effect.
//   Arithmetic: {rsp_cout,rsp_sum} = x + y + cin modulo 2^(WIDTH+1);
//     all-ones + 1 gives sum 0, cout 1.
//   cnt width is clog2(CHUNKS) (min 1). cnt does not wrap past CHUNKS-1.
// STRUCTURE
//   Shared package adder_sched_pkg:
//     - CHUNK_W=3
//     - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
//     - clog2 function
//   Sub-module rr_arbiter(NUM_REQ): req, ptr -> one-hot grant + index.
//   The shared adder is instantiated by the parent and wired to the add_* ports.
// TESTING  (NUM_REQ=4, CHUNKS=3, WIDTH=9)
//   1. Single request, req0 x=9'h1FF, y=9'h001, cin=0 -> accept cycle 0;
//      rsp_valid in cycle 4 with sum=9'h000, cout=1, id=0.
//   2. Carry-in only, req2 x=0, y=0, cin=1 -> sum=9'h001, cout=0, id=2.
//      add_cin=1 only on chunk 0.
//   3. All four requests held valid, rsp_ready=1 -> grant order 0,1,2,3,0.
//      One accept every 5 cycles.
//   4. Backpressure: rsp_ready=0 for 6 cycles after rsp_valid -> outputs stable
//      and req_ready=0 throughout; response completes on the first rsp_ready=1.
//   5. Reset asserted in the second RUN cycle -> rsp_valid=0 and req_ready=0 during reset;
//      after release, req0 is served first and the aborted transaction is never reported.
//   6. Mixed chunks, req1 x=9'o525, y=9'o253, cin=0 -> sum=9'o000, cout=1.
//      add_out sequence per chunk is 0,0,0 with carry 1 each chunk.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the chunked-adder scheduler.
//   CHUNK_W : width of the external shared adder (one chunk per cycle)
//   state_t : scheduler FSM encoding
//   clog2   : ceiling log2, never below 1 so a single-entry index still has a bit
package adder_sched_pkg;

  localparam int CHUNK_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request after ptr (with wrap) wins.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  ID_W     index of the most recently served requester
//   grant     out NUM_REQ  one-hot grant (zero when nothing requests)
//   grant_id  out ID_W     index of the granted requester
//   grant_vld out 1        some request was granted
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_vld
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    cand      = '0;
    // Offsets 1..NUM_REQ visit ptr+1 first and ptr itself last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_chunk_scheduler.sv
// Shares one external 3-bit adder among NUM_REQ requesters. A granted add is
// stepped through the adder one chunk per cycle, LSB first, with the carry
// held in a register between chunks. State updates on the falling clock edge.
// Ports:
//   clk, reset            clock (negedge active), async active-high reset
//   req_valid/ready       per-requester handshake, ready is one-hot or zero
//   req_x/req_y/req_cin   packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_x/add_y/add_cin   current chunk to the shared adder (0 outside RUN)
//   add_out/add_cout      combinational result from the shared adder
//   rsp_valid/ready       response handshake
//   rsp_id/sum/cout       served requester, sum and final carry
module adder_chunk_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CHUNKS  = 3,
  localparam int WIDTH   = CHUNK_W * CHUNKS,
  localparam int ID_W    = clog2(NUM_REQ),
  localparam int CNT_W   = clog2(CHUNKS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [CHUNK_W-1:0]       add_x,
  output logic [CHUNK_W-1:0]       add_y,
  output logic                     add_cin,
  input  logic [CHUNK_W-1:0]       add_out,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic [CHUNK_W-1:0] chunk_x, chunk_y;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  always_comb begin
    chunk_x = '0;
    chunk_y = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (cnt_q == CNT_W'(c)) begin
        chunk_x = x_q[c*CHUNK_W +: CHUNK_W];
        chunk_y = y_q[c*CHUNK_W +: CHUNK_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    id_d      = id_q;
    rr_d      = rr_q;
    sum_d     = sum_q;
    x_d       = x_q;
    y_d       = y_q;
    req_ready = '0;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset is asynchronous, so ready is also masked while it is held.
        if (!reset) req_ready = grant;
        if (grant_vld) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
              x_d     = req_x[i*WIDTH +: WIDTH];
              y_d     = req_y[i*WIDTH +: WIDTH];
              carry_d = req_cin[i];
            end
          end
          id_d    = grant_id;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_x   = chunk_x;
        add_y   = chunk_y;
        add_cin = carry_q;
        for (int c = 0; c < CHUNKS; c++) begin
          if (cnt_q == CNT_W'(c)) sum_d[c*CHUNK_W +: CHUNK_W] = add_out;
        end
        carry_d = add_cout;
        // cnt parks on the last chunk instead of wrapping.
        if (cnt_q == CNT_W'(CHUNKS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rr_d    = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      sum_q   <= sum_d;
    end
  end

  // Operand copies are only meaningful after an accept, so they carry no reset.
  always_ff @(negedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_chunk_scheduler.sv
module tb_adder_chunk_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CHUNKS  = 3;
  localparam int WIDTH   = 9;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_x;
  logic [NUM_REQ*WIDTH-1:0] req_y;
  logic [NUM_REQ-1:0]       req_cin;
  logic [2:0]               add_x, add_y, add_out;
  logic                     add_cin, add_cout;
  logic                     rsp_valid, rsp_ready, rsp_cout;
  logic [1:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference model of the external 3-bit adder.
  assign {add_cout, add_out} = {1'b0, add_x} + {1'b0, add_y} + {3'b000, add_cin};

  adder_chunk_scheduler #(.NUM_REQ(NUM_REQ), .CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_cin   (req_cin),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_out   (add_out),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  typedef struct {
    logic [1:0] id;
    logic [8:0] x;
    logic [8:0] y;
    logic       cin;
    logic [8:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_cin   = '0;
    repeat (2) @(posedge clk);
    reset = 1'b0;
  endtask

  // One isolated request: accept cycle, CHUNKS RUN cycles, then the response.
  task automatic run_vec(input vec_t v);
    int xi, yi, ci, mask;
    xi = int'(v.x);
    yi = int'(v.y);
    ci = int'(v.cin);
    @(posedge clk);
    req_valid = 4'b0001 << v.id;
    req_x = '0;
    req_y = '0;
    req_cin = '0;
    req_x[v.id*WIDTH +: WIDTH] = v.x;
    req_y[v.id*WIDTH +: WIDTH] = v.y;
    req_cin[v.id] = v.cin;
    rsp_ready = 1'b1;
    #1;
    check("accept_ready", 32'(req_ready), 32'(4'b0001 << v.id));
    check("idle_add_x", 32'(add_x), 32'd0);
    for (int c = 0; c < CHUNKS; c++) begin
      @(posedge clk);
      // Other requesters clamour and the operands get scrambled; neither may matter.
      req_valid = 4'b1111;
      req_x = '1;
      req_y = '1;
      req_cin = '1;
      #1;
      mask = (1 << (3 * c)) - 1;
      check("run_add_x", 32'(add_x), 32'((xi >> (3 * c)) & 7));
      check("run_add_y", 32'(add_y), 32'((yi >> (3 * c)) & 7));
      check("run_add_cin", 32'(add_cin),
            32'((c == 0) ? ci : (((xi & mask) + (yi & mask) + ci) >> (3 * c)) & 1));
      check("run_ready", 32'(req_ready), 32'd0);
      check("run_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    req_valid = '0;
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_sum", 32'(rsp_sum), 32'(v.sum));
    check("rsp_cout", 32'(rsp_cout), 32'(v.cout));
    check("rsp_id", 32'(rsp_id), 32'(v.id));
    check("done_add_cin", 32'({add_x, add_y, add_cin}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [8:0] rr_x[4];
    logic [8:0] rr_y[4];
    logic [9:0] rr_exp[4];
    int n_acc, n_rsp, idx, first_rsp;

    vecs[0] = '{2'd0, 9'h1FF, 9'h001, 1'b0, 9'h000, 1'b1};
    vecs[1] = '{2'd2, 9'h000, 9'h000, 1'b1, 9'h001, 1'b0};
    vecs[2] = '{2'd1, 9'o525, 9'o253, 1'b0, 9'o000, 1'b1};
    vecs[3] = '{2'd3, 9'h0FF, 9'h101, 1'b1, 9'h001, 1'b1};
    vecs[4] = '{2'd0, 9'h123, 9'h045, 1'b0, 9'h168, 1'b0};
    vecs[5] = '{2'd1, 9'h1FF, 9'h1FF, 1'b1, 9'h1FF, 1'b1};
    vecs[6] = '{2'd2, 9'h0AA, 9'h055, 1'b0, 9'h0FF, 1'b0};

    // Reset state, with every requester asserting valid.
    reset     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_x     = '0;
    req_y     = '0;
    req_cin   = '0;
    @(posedge clk);
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset_rsp_cout", 32'(rsp_cout), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_add", 32'({add_x, add_y, add_cin}), 32'd0);
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // All four held valid: round-robin grants 0,1,2,3,0 every five cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rr_x[i]   = 9'h0F0 + 9'(i * 19);
      rr_y[i]   = 9'h055 + 9'(i * 33);
      rr_exp[i] = {1'b0, rr_x[i]} + {1'b0, rr_y[i]} + 10'(i & 1);
    end
    n_acc = 0;
    n_rsp = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk);
      if (cyc == 0) begin
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          req_x[i*WIDTH +: WIDTH] = rr_x[i];
          req_y[i*WIDTH +: WIDTH] = rr_y[i];
          req_cin[i] = (i % 2) == 1;
        end
      end
      #1;
      if (req_ready != 4'b0000) begin
        if (n_acc < 5) begin
          check("rr_accept_cycle", 32'(cyc), 32'(n_acc * 5));
          check("rr_grant", 32'(req_ready), 32'(4'b0001 << (n_acc % 4)));
        end
        n_acc++;
      end
      if (rsp_valid) begin
        idx = n_rsp % 4;
        check("rr_rsp_id", 32'(rsp_id), 32'(idx));
        check("rr_rsp_result", 32'({rsp_cout, rsp_sum}), 32'(rr_exp[idx]));
        n_rsp++;
      end
    end
    check("rr_accept_count", 32'(n_acc), 32'd5);
    check("rr_rsp_count", 32'(n_rsp), 32'd5);

    // Backpressure: rsp_ready low for six cycles of rsp_valid.
    do_reset();
    @(posedge clk);
    req_valid = 4'b1000;
    req_x[3*WIDTH +: WIDTH] = 9'h0A5;
    req_y[3*WIDTH +: WIDTH] = 9'h03C;
    req_cin = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    check("bp_accept", 32'(req_ready), 32'b1000);
    for (int cyc = 1; cyc < 4; cyc++) begin
      @(posedge clk);
      req_valid = 4'b1111;
      req_x = '1;
      #1;
      check("bp_run_ready", 32'(req_ready), 32'd0);
    end
    for (int cyc = 4; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_sum", 32'(rsp_sum), 32'h0E2);
      check("bp_hold_cout", 32'(rsp_cout), 32'd0);
      check("bp_hold_id", 32'(rsp_id), 32'd3);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    check("bp_release_sum", 32'(rsp_sum), 32'h0E2);
    @(posedge clk);
    #1;
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_grant", 32'(req_ready), 32'b0001);

    // Reset during the second RUN cycle aborts the req2 transaction.
    do_reset();
    @(posedge clk);
    req_valid = 4'b0100;
    req_x[2*WIDTH +: WIDTH] = 9'h1FF;
    req_y[2*WIDTH +: WIDTH] = 9'h001;
    rsp_ready = 1'b1;
    #1;
    check("abort_accept", 32'(req_ready), 32'b0100);
    @(posedge clk);
    req_valid = '0;
    for (int cyc = 2; cyc < 4; cyc++) begin
      @(posedge clk);
      reset = 1'b1;
      req_valid = 4'b1111;
      #1;
      check("abort_rst_valid", 32'(rsp_valid), 32'd0);
      check("abort_rst_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    reset = 1'b0;
    req_valid = 4'b0101;
    req_x[0 +: WIDTH] = 9'h005;
    req_y[0 +: WIDTH] = 9'h006;
    req_cin = '0;
    #1;
    check("abort_first_grant", 32'(req_ready), 32'b0001);
    n_rsp = 0;
    first_rsp = -1;
    for (int cyc = 5; cyc < 13; cyc++) begin
      @(posedge clk);
      req_valid = '0;
      #1;
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = cyc;
        n_rsp++;
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        check("abort_rsp_sum", 32'({rsp_cout, rsp_sum}), 32'h00B);
      end
    end
    check("abort_rsp_count", 32'(n_rsp), 32'd1);
    check("abort_rsp_cycle", 32'(first_rsp), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
